// File: rtl/subword_sbox_sched.sv
// subword_sbox_sched: time-multiplexed SubWord engine shared by two requesters.
// Port A (key expansion) and port B (cipher word lane) arbitrate round-robin
// for one combinational AES S-box. Each accepted word is substituted one byte
// per cycle over four cycles, then returned as a single-cycle result pulse.
// Optional feature macro: SUBWORD_ROTWORD_EN (port A words get RotWord first).
module subword_sbox_sched #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_word,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_word,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] word;
  logic [31:0] result;
  logic        owner;    // 0 = A, 1 = B
  logic        rr_last;  // last served requester: 0 = A, 1 = B
  logic        grant_a;
  logic        grant_b;
  logic [31:0] a_in;
  logic [4:0]  byte_lsb;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;

`ifdef SUBWORD_ROTWORD_EN
  assign a_in = {a_word[23:0], a_word[31:24]};
`else
  assign a_in = a_word;
`endif

  // Byte 0 lives in [31:24], so idx selects downward from the top of the word.
  assign byte_lsb = {~idx, 3'b000};
  assign sbox_in  = word[byte_lsb +: 8];
  assign sbox_out = SBOX[sbox_in];

  // Round-robin grant, only offered while idle; ties go to the requester not served last.
  always_comb begin
    // NOTE: defaults first so every path assigns both grants and no latch is inferred.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (a_valid && b_valid) begin
        grant_a = rr_last;
        grant_b = ~rr_last;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign busy    = (state != IDLE);

  // Scheduler FSM: accept, four byte substitutions, one-cycle result pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      word     <= '0;
      result   <= '0;
      owner    <= 1'b0;
      rr_last  <= RR_INIT;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a) begin
            word    <= a_in;
            owner   <= 1'b0;
            rr_last <= 1'b0;
            idx     <= 2'd0;
            state   <= SUB;
          end else if (grant_b) begin
            word    <= b_word;
            owner   <= 1'b1;
            rr_last <= 1'b1;
            idx     <= 2'd0;
            state   <= SUB;
          end
        end
        SUB: begin
          result[byte_lsb +: 8] <= sbox_out;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= DONE;
            if (owner) begin
              b_rvalid <= 1'b1;
              b_rdata  <= {result[31:8], sbox_out};
            end else begin
              a_rvalid <= 1'b1;
              a_rdata  <= {result[31:8], sbox_out};
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subword_sbox_sched.sv
// Testbench for subword_sbox_sched: table-driven single-port requests plus
// hand-written sequences for arbitration, reset abort and dropped requests.
module tb_subword_sbox_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [31:0] a_word = '0;
  logic        a_rvalid;
  logic [31:0] a_rdata;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [31:0] b_word = '0;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          port;   // 0 = A, 1 = B
    logic [31:0] word;
    logic [31:0] exp;    // plain SubWord(word)
  } vec_t;

  vec_t vecs [8];

  subword_sbox_sched #(.RR_INIT(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_word  (a_word),
    .a_rvalid(a_rvalid),
    .a_rdata (a_rdata),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_word  (b_word),
    .b_rvalid(b_rvalid),
    .b_rdata (b_rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected result seen on a port: A words are rotated first when RotWord is enabled.
  function automatic logic [31:0] port_exp(input bit port, input logic [31:0] e);
`ifdef SUBWORD_ROTWORD_EN
    if (!port) return {e[23:0], e[31:24]};
`endif
    return e;
  endfunction

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One request on a single port; the input word is corrupted right after acceptance.
  task automatic run_one(input int n, input bit port, input logic [31:0] w, input logic [31:0] exp);
    @(negedge clk);
    if (port) begin b_valid = 1'b1; b_word = w; end
    else      begin a_valid = 1'b1; a_word = w; end
    #1;
    check($sformatf("v%0d ready", n), port ? b_ready : a_ready, 1);
    check($sformatf("v%0d other ready", n), port ? a_ready : b_ready, 0);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_word  = ~w;
    b_word  = ~w;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("v%0d rvalid T+%0d", n, k), port ? b_rvalid : a_rvalid, (k == 4));
      check($sformatf("v%0d other rvalid T+%0d", n, k), port ? a_rvalid : b_rvalid, 0);
      check($sformatf("v%0d busy T+%0d", n, k), busy, 1);
    end
    check($sformatf("v%0d rdata", n), port ? b_rdata : a_rdata, exp);
    @(posedge clk);
    #1;
    check($sformatf("v%0d rvalid after", n), port ? b_rvalid : a_rvalid, 0);
    check($sformatf("v%0d busy after", n), busy, 0);
    check($sformatf("v%0d rdata hold", n), port ? b_rdata : a_rdata, exp);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h00010253, 32'h637c77ed};
    vecs[1] = '{1'b1, 32'h09cf4f3c, 32'h018a84eb};
    vecs[2] = '{1'b0, 32'h09cf4f3c, 32'h018a84eb};
    vecs[3] = '{1'b0, 32'h00000000, 32'h63636363};
    vecs[4] = '{1'b1, 32'hffffffff, 32'h16161616};
    vecs[5] = '{1'b0, 32'h01234567, 32'h7c266e85};
    vecs[6] = '{1'b1, 32'h89abcdef, 32'ha762bddf};
    vecs[7] = '{1'b0, 32'h89abcdef, 32'ha762bddf};

    // Reset state.
    do_reset();
    check("rst busy", busy, 0);
    check("rst a_ready", a_ready, 0);
    check("rst b_ready", b_ready, 0);
    check("rst a_rvalid", a_rvalid, 0);
    check("rst b_rvalid", b_rvalid, 0);
    check("rst a_rdata", a_rdata, 0);
    check("rst b_rdata", b_rdata, 0);

    // Both valid from reset with RR_INIT = 0: grants B, A, B six cycles apart.
    @(negedge clk);
    a_valid = 1'b1; a_word = 32'h00010253;
    b_valid = 1'b1; b_word = 32'h09cf4f3c;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      check($sformatf("arb b_ready c%0d", cyc), b_ready, (cyc == 0 || cyc == 12));
      check($sformatf("arb a_ready c%0d", cyc), a_ready, (cyc == 6));
      check($sformatf("arb b_rvalid c%0d", cyc), b_rvalid, (cyc == 5 || cyc == 17));
      check($sformatf("arb a_rvalid c%0d", cyc), a_rvalid, (cyc == 11));
      if (b_rvalid) check($sformatf("arb b_rdata c%0d", cyc), b_rdata, 32'h018a84eb);
      if (a_rvalid) check($sformatf("arb a_rdata c%0d", cyc), a_rdata, port_exp(1'b0, 32'h637c77ed));
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clk);
    #1 check("arb idle busy", busy, 0);

    // Table of single-port requests.
    for (int i = 0; i < 8; i++)
      run_one(i, vecs[i].port, vecs[i].word, port_exp(vecs[i].port, vecs[i].exp));

    // B pulsed for one cycle while busy with an A word: never accepted, never answered.
    @(negedge clk);
    a_valid = 1'b1; a_word = 32'h01234567;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(posedge clk);
    #1 b_valid = 1'b1; b_word = 32'h55555555;
    #1 check("pulse b_ready", b_ready, 0);
    @(posedge clk);
    #1 b_valid = 1'b0;
    for (int k = 3; k <= 14; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("pulse b_rvalid T+%0d", k), b_rvalid, 0);
      check($sformatf("pulse b_ready T+%0d", k), b_ready, 0);
      check($sformatf("pulse a_rvalid T+%0d", k), a_rvalid, (k == 4));
      if (k == 4) check("pulse a_rdata", a_rdata, port_exp(1'b0, 32'h7c266e85));
    end

    // Reset during the third substitution cycle aborts the A word.
    @(negedge clk);
    a_valid = 1'b1; a_word = 32'hdeadbeef;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0; a_valid = 1'b1;
    @(posedge clk);
    #1 check("abort a_rvalid T+3", a_rvalid, 0);
    @(posedge clk);
    #1 check("abort a_rvalid T+4", a_rvalid, 0);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort a_ready", a_ready, 1);
    check("abort a_rdata", a_rdata, 0);
    a_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort a_rvalid late %0d", k), a_rvalid, 0);
      check($sformatf("abort busy late %0d", k), busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
